// File: rtl/bin2bcd_seq_if.sv
// bin2bcd_seq_if
//   Handshake and data bundle for the sequential binary-to-BCD converter.
//   master : requester side (drives start/bin, observes busy/done/bcd/ovf)
//   slave  : converter side
// Signals:
//   start  request a conversion, sampled on rising clk
//   bin    unsigned binary operand, captured when start is accepted
//   busy   conversion in progress
//   done   one-cycle pulse when bcd/ovf update
//   bcd    packed BCD result, digit 0 in [3:0], held between conversions
//   ovf    last captured operand exceeded 10^DIGITS-1, held with bcd
interface bin2bcd_seq_if #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (output start, bin, input busy, done, bcd, ovf);
    modport slave  (input start, bin, output busy, done, bcd, ovf);
endinterface

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble (shift-add-3) converter, one iteration per clock.
//   Feeds a seven-segment driver directly, so the result register only
//   changes on completion; overflow is shown as all-ones ("FFFF").
// Ports:
//   clk    system clock
//   reset  asynchronous, active-high reset
//   io     bin2bcd_seq_if.slave (start, bin, busy, done, bcd, ovf)
// Parameters:
//   IN_WIDTH  binary operand width (4..20)
//   DIGITS    BCD digits produced; bcd is 4*DIGITS wide
module bin2bcd_seq #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
) (
    input  logic           clk,
    input  logic           reset,
    bin2bcd_seq_if.slave   io
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < n; i++) p = p * 64'd10;
        return p;
    endfunction

    // Largest value representable in DIGITS decimal digits. When IN_WIDTH is
    // narrow enough this makes the range check a constant false.
    localparam logic [63:0] DEC_MAX = pow10(DIGITS) - 64'd1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state_q, state_d;
    logic [IN_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]       scratch_q, scratch_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_pend_q, ovf_pend_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic                ovf_q, ovf_d;
    logic                done_q, done_d;

    // Per-digit add-3 correction ahead of the shift.
    logic [BW-1:0] adj;
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        logic [3:0] dig;
        assign dig          = scratch_q[4*g +: 4];
        assign adj[4*g +: 4] = (dig >= 4'd5) ? dig + 4'd3 : dig;
    end

    // Joint left shift of {scratch, shift}; the scratch MSB falls off, which
    // only happens on operands that are flagged as overflow anyway.
    logic [BW+IN_WIDTH-1:0] cat_sh;
    assign cat_sh = {adj, shift_q} << 1;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (io.start) begin
                    state_d    = SHIFT;
                    shift_d    = io.bin;
                    scratch_d  = '0;
                    cnt_d      = '0;
                    ovf_pend_d = (64'(io.bin) > DEC_MAX);
                end
            end
            SHIFT: begin
                scratch_d = cat_sh[BW+IN_WIDTH-1:IN_WIDTH];
                shift_d   = cat_sh[IN_WIDTH-1:0];
                cnt_d     = cnt_q + CW'(1);
                if (cnt_q == CW'(IN_WIDTH - 1)) begin
                    bcd_d   = ovf_pend_q ? '1 : cat_sh[BW+IN_WIDTH-1:IN_WIDTH];
                    ovf_d   = ovf_pend_q;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
            done_q     <= done_d;
        end
    end

    assign io.busy = (state_q == SHIFT);
    assign io.done = done_q;
    assign io.bcd  = bcd_q;
    assign io.ovf  = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.IN_WIDTH(14), .DIGITS(4)) io ();
    bin2bcd_seq_if #(.IN_WIDTH(7),  .DIGITS(3)) io2 ();

    bin2bcd_seq #(.IN_WIDTH(14), .DIGITS(4)) dut  (.clk(clk), .reset(reset), .io(io));
    bin2bcd_seq #(.IN_WIDTH(7),  .DIGITS(3)) dut2 (.clk(clk), .reset(reset), .io(io2));

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [16:0] last = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input int v, input int due);
        exp_t e;
        e.due = due;
        if (v > 9999) begin
            e.bcd = 16'hFFFF;
            e.ovf = 1'b1;
        end else begin
            e.bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard monitor: pops on done, and checks bcd/ovf are held otherwise.
    always @(negedge clk) begin
        if (reset) begin
            last = '0;
        end else if (io.done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_cycle", 64'(cyc), 64'(e.due));
                chk("bcd", 64'(io.bcd), 64'(e.bcd));
                chk("ovf", 64'(io.ovf), 64'(e.ovf));
            end
            chk("busy_in_done", 64'(io.busy), 64'(0));
            last = {io.ovf, io.bcd};
        end else begin
            chk("hold", 64'({io.ovf, io.bcd}), 64'(last));
        end
    end

    // Drive one start pulse; returns at the negedge after the accepting edge.
    task automatic conv(input int v);
        @(negedge clk);
        io.bin   = 14'(v);
        io.start = 1'b1;
        sb.push_back(model(v, cyc + 1 + 14));
        @(negedge clk);
        io.start = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("sb_drain", 64'(sb.size()), 64'(0));
    endtask

    initial begin
        int t0;
        reset     = 1'b1;
        io.start  = 1'b0;
        io.bin    = '0;
        io2.start = 1'b0;
        io2.bin   = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(io.busy), 64'(0));
        chk("rst_done", 64'(io.done), 64'(0));
        chk("rst_bcd",  64'(io.bcd),  64'(0));
        chk("rst_ovf",  64'(io.ovf),  64'(0));
        reset = 1'b0;

        // Basic conversion with busy window and hold afterwards
        conv(1234);
        chk("busy_first", 64'(io.busy), 64'(1));
        repeat (13) begin
            @(negedge clk);
            chk("busy_run", 64'(io.busy), 64'(1));
        end
        wait_done();
        repeat (20) @(negedge clk);
        chk("bcd_idle", 64'(io.bcd), 64'(16'h1234));
        chk("busy_idle", 64'(io.busy), 64'(0));

        // Boundaries
        conv(0);     wait_done();
        conv(9999);  wait_done();
        conv(16383); wait_done();
        conv(10000); wait_done();
        conv(1);     wait_done();

        // start while busy is ignored; bin change after accept ignored
        conv(4321);
        repeat (4) @(negedge clk);
        io.bin   = 14'd55;
        io.start = 1'b1;
        @(negedge clk);
        io.start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("after_busy_start", 64'(io.bcd), 64'(16'h4321));

        // start held high: back-to-back conversions every 15 cycles
        @(negedge clk);
        io.bin   = 14'd42;
        io.start = 1'b1;
        t0 = cyc;
        sb.push_back(model(42, t0 + 15));
        @(negedge clk);
        io.bin = 14'd7;
        sb.push_back(model(7, t0 + 30));
        chk("held_busy", 64'(io.busy), 64'(1));
        repeat (15) begin
            @(negedge clk);
            chk("held_busy", 64'(io.busy), 64'(!io.done));
        end
        io.start = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);

        // Reset mid-conversion
        conv(1234); wait_done();
        conv(8765);
        repeat (5) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_busy", 64'(io.busy), 64'(0));
        chk("arst_done", 64'(io.done), 64'(0));
        chk("arst_bcd",  64'(io.bcd),  64'(0));
        chk("arst_ovf",  64'(io.ovf),  64'(0));
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (25) @(negedge clk);
        chk("post_rst_idle", 64'(io.busy), 64'(0));
        chk("post_rst_bcd",  64'(io.bcd),  64'(0));
        conv(8765); wait_done();

        // Narrow instance: 7-bit input, 3 digits, overflow impossible
        @(negedge clk);
        io2.bin   = 7'd127;
        io2.start = 1'b1;
        @(negedge clk);
        io2.start = 1'b0;
        t0 = cyc;
        for (int i = 0; i < 30 && !io2.done; i++) @(negedge clk);
        chk("n_done", 64'(io2.done), 64'(1));
        chk("n_lat",  64'(cyc - t0), 64'(7));
        chk("n_bcd",  64'(io2.bcd),  64'(12'h127));
        chk("n_ovf",  64'(io2.ovf),  64'(0));
        @(negedge clk);
        chk("n_pulse", 64'(io2.done), 64'(0));

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
